// File: rtl/vga_timing_gen_if.sv
// Renderer/pin bundle for the VGA raster generator: raster coordinates out, colour in,
// blanked colour and sync pins out.
interface vga_timing_gen_if;
  logic [11:0] rgb;
  logic        pix_en;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        frame_tick;
  logic        hSync;
  logic        vSync;
  logic [3:0]  vgaR;
  logic [3:0]  vgaG;
  logic [3:0]  vgaB;

  modport master (
    input  rgb,
    output pix_en, hCount, vCount, bright, frame_tick, hSync, vSync, vgaR, vgaG, vgaB
  );

  modport slave (
    output rgb,
    input  pix_en, hCount, vCount, bright, frame_tick, hSync, vSync, vgaR, vgaG, vgaB
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster timing: pixel-rate divider, h/v counters, visible-window flag and a
// registered output stage that keeps blanked colour and syncs aligned to the same pixel.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_START = 144,
  parameter int unsigned H_END   = 784,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_START = 35,
  parameter int unsigned V_END   = 515
) (
  input logic               Clk,
  input logic               Reset,
  vga_timing_gen_if.master  bus
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            pix_en_q, pix_en_d;
  logic [9:0]      h_q, h_d, v_q, v_d;
  logic            bright_q, bright_d;
  logic            frame_tick_q, frame_tick_d;
  logic            hsync_q, hsync_d, vsync_q, vsync_d;
  logic [11:0]     rgb_q, rgb_d;
  logic            h_wrap, v_wrap;

  assign h_wrap = (h_q == 10'(H_TOTAL - 1));
  assign v_wrap = (v_q == 10'(V_TOTAL - 1));

  always_comb begin
    div_cnt_d    = (div_cnt_q == DivW'(CLK_DIV - 1)) ? '0 : div_cnt_q + DivW'(1);
    // Registered strobe: high while div_cnt sits at its terminal value.
    pix_en_d     = (div_cnt_d == DivW'(CLK_DIV - 1));
    h_d          = h_q;
    v_d          = v_q;
    bright_d     = bright_q;
    frame_tick_d = 1'b0;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    rgb_d        = rgb_q;
    if (pix_en_q) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      end
      bright_d     = (h_d >= 10'(H_START)) && (h_d < 10'(H_END)) &&
                     (v_d >= 10'(V_START)) && (v_d < 10'(V_END));
      frame_tick_d = h_wrap && v_wrap;
      // Output stage uses the pre-update coordinate so colour and sync describe one pixel.
      rgb_d        = bright_q ? bus.rgb : 12'h000;
      hsync_d      = ~(h_q < 10'(H_SYNC));
      vsync_d      = ~(v_q < 10'(V_SYNC));
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt_q    <= '0;
      pix_en_q     <= 1'b0;
      h_q          <= 10'd0;
      v_q          <= 10'd0;
      bright_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      rgb_q        <= 12'h000;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pix_en_q     <= pix_en_d;
      h_q          <= h_d;
      v_q          <= v_d;
      bright_q     <= bright_d;
      frame_tick_q <= frame_tick_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      rgb_q        <= rgb_d;
    end
  end

  assign bus.pix_en     = pix_en_q;
  assign bus.hCount     = h_q;
  assign bus.vCount     = v_q;
  assign bus.bright     = bright_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.hSync      = hsync_q;
  assign bus.vSync      = vsync_q;
  assign bus.vgaR       = rgb_q[11:8];
  assign bus.vgaG       = rgb_q[7:4];
  assign bus.vgaB       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so whole frames fit in a short run; a
// cycle-count model predicts the counters and a queue carries expected pin values.
module tb_vga_timing_gen;

  localparam int unsigned D   = 4;
  localparam int unsigned HT  = 24;
  localparam int unsigned HS  = 4;
  localparam int unsigned HST = 6;
  localparam int unsigned HEN = 20;
  localparam int unsigned VT  = 12;
  localparam int unsigned VS  = 2;
  localparam int unsigned VST = 3;
  localparam int unsigned VEN = 10;

  typedef struct packed {
    logic [11:0] col;
    logic        hs;
    logic        vs;
  } pins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .CLK_DIV (D),
    .H_TOTAL (HT),
    .H_SYNC  (HS),
    .H_START (HST),
    .H_END   (HEN),
    .V_TOTAL (VT),
    .V_SYNC  (VS),
    .V_START (VST),
    .V_END   (VEN)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (vif)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  pins_t sb_q[$];
  pins_t pins_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  function automatic bit in_win(input int h, input int v);
    return (h >= int'(HST)) && (h < int'(HEN)) && (v >= int'(VST)) && (v < int'(VEN));
  endfunction

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_pix_en"}, 32'(vif.pix_en), 32'd0);
    check_eq({pfx, "_hcount"}, 32'(vif.hCount), 32'd0);
    check_eq({pfx, "_vcount"}, 32'(vif.vCount), 32'd0);
    check_eq({pfx, "_bright"}, 32'(vif.bright), 32'd0);
    check_eq({pfx, "_frame_tick"}, 32'(vif.frame_tick), 32'd0);
    check_eq({pfx, "_hsync"}, 32'(vif.hSync), 32'd1);
    check_eq({pfx, "_vsync"}, 32'(vif.vSync), 32'd1);
    check_eq({pfx, "_colour"}, 32'({vif.vgaR, vif.vgaG, vif.vgaB}), 32'd0);
  endtask

  // cyc counts Clk cycles since reset release; k pixel updates have completed by cycle cyc.
  task automatic run(input int ncyc, input bit rand_rgb);
    int          k, h, v;
    bit          br;
    logic [11:0] c;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      k  = cyc / int'(D);
      h  = k % int'(HT);
      v  = (k / int'(HT)) % int'(VT);
      br = (k > 0) && in_win(h, v);
      check_eq("pix_en", 32'(vif.pix_en), 32'((cyc % int'(D)) == int'(D) - 1));
      check_eq("hcount", 32'(vif.hCount), 32'(h));
      check_eq("vcount", 32'(vif.vCount), 32'(v));
      check_eq("bright", 32'(vif.bright), 32'(br));
      check_eq("frame_tick", 32'(vif.frame_tick),
               32'((cyc % int'(D) == 0) && (k > 0) && (h == 0) && (v == 0)));
      if ((k > 0) && (cyc % int'(D) == 0)) begin
        check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) pins_exp = sb_q.pop_front();
      end
      check_eq("colour", 32'({vif.vgaR, vif.vgaG, vif.vgaB}), 32'(pins_exp.col));
      check_eq("hsync", 32'(vif.hSync), 32'(pins_exp.hs));
      check_eq("vsync", 32'(vif.vSync), 32'(pins_exp.vs));
      c       = rand_rgb ? 12'($urandom) : 12'hF00;
      vif.rgb = c;
      if (cyc % int'(D) == int'(D) - 1) begin
        sb_q.push_back('{col: (br ? c : 12'h000), hs: !(h < int'(HS)), vs: !(v < int'(VS))});
      end
      cyc++;
    end
  endtask

  initial begin
    vif.rgb  = 12'h000;
    pins_exp = '{col: 12'h000, hs: 1'b1, vs: 1'b1};
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    @(posedge clk);
    #2 rst = 1'b0;
    cyc = 0;
    run(1300, 1'b0);
    run(1700, 1'b1);
    // Asynchronous reset mid-frame, between clock edges.
    #1 rst = 1'b1;
    #1 check_reset_vals("midrst");
    sb_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    cyc      = 0;
    pins_exp = '{col: 12'h000, hs: 1'b1, vs: 1'b1};
    run(1500, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
